// File: rtl/apb_master_bridge.sv
// APB master: local command interface to NUM_SLV address-decoded APB slaves.
// Optional wait-state timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SLV = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      trans,
  input  logic                      re_wr,
  input  logic [ADDR_W-1:0]         wr_paddr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         re_paddr,
  output logic                      cmd_ready,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic                      done,
  output logic [DATA_W-1:0]         pdata,
  output logic                      err
);

  localparam int unsigned SEL_W = $clog2(NUM_SLV);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]         state, state_d;
  logic [SEL_W-1:0]   idx, new_idx;
  logic [ADDR_W-1:0]  new_addr;
  logic               sel_ready, sel_err, accept, timed_out;
  logic [DATA_W-1:0]  sel_rdata;

  logic [NUM_SLV-1:0] psel_d;
  logic               penable_d, pwrite_d, done_d, err_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [DATA_W-1:0]  pwdata_d, pdata_d;

  // The active slave is decoded from the registered address, which is stable in SETUP/ACCESS
  assign idx       = paddr[ADDR_W-1 -: SEL_W];
  assign new_addr  = re_wr ? wr_paddr : re_paddr;
  assign new_idx   = new_addr[ADDR_W-1 -: SEL_W];
  assign sel_ready = pready[idx];
  assign sel_err   = pslverr[idx];
  assign sel_rdata = prdata[32'(idx)*DATA_W +: DATA_W];

  assign cmd_ready = (state == ST_IDLE) || ((state == ST_ACCESS) && sel_ready);
  assign accept    = trans && cmd_ready;

`ifdef APB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timed_out = (state == ST_ACCESS) && !sel_ready && (wait_cnt == 8'(TIMEOUT - 1));

  // Consecutive wait cycles of the current ACCESS phase
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= 8'd0;
    end else if ((state == ST_ACCESS) && !sel_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    psel_d    = psel;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    done_d    = 1'b0;
    pdata_d   = pdata;
    err_d     = err;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d          = ST_SETUP;
          psel_d           = '0;
          psel_d[new_idx]  = 1'b1;
          penable_d        = 1'b0;
          pwrite_d         = re_wr;
          paddr_d          = new_addr;
          pwdata_d         = wr_data;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          done_d = 1'b1;
          err_d  = sel_err;
          if (!pwrite) begin
            pdata_d = sel_rdata;
          end
          if (accept) begin
            state_d          = ST_SETUP;
            psel_d           = '0;
            psel_d[new_idx]  = 1'b1;
            penable_d        = 1'b0;
            pwrite_d         = re_wr;
            paddr_d          = new_addr;
            pwdata_d         = wr_data;
          end else begin
            state_d   = ST_IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
          end
        end else if (timed_out) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= ST_IDLE;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done    <= 1'b0;
      pdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      done    <= done_d;
      pdata   <= pdata_d;
      err     <= err_d;
    end
  end

endmodule
